// File: rtl/trivium_lite_pkg.sv
// Shared definitions for the trivium_lite cipher. The transmitter and receiver both
// import this package, so the seed expansion and step rules exist in one place only.
package trivium_lite_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GEN     = 2'd1,
        WAIT_CT = 2'd2,
        EMIT    = 2'd3
    } tl_state_e;

    typedef struct packed {
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
    } tl_regs_t;

    localparam logic [7:0] INIT_S1      = 8'h01;
    localparam logic [7:0] INIT_S2      = 8'h02;
    localparam logic [7:0] INIT_S3      = 8'h03;
    localparam logic [7:0] SEED_XOR     = 8'hA5;
    localparam logic [7:0] SEED_RSVD_LO = 8'h00;
    localparam logic [7:0] SEED_RSVD_HI = 8'hFF;

    function automatic logic seed_is_reserved(input logic [7:0] seed);
        return (seed == SEED_RSVD_LO) || (seed == SEED_RSVD_HI);
    endfunction

    function automatic tl_regs_t seed_expand(input logic [7:0] seed);
        tl_regs_t r;
        r.s1 = seed;
        r.s2 = {~seed[3:0], seed[7:4]};
        r.s3 = seed ^ SEED_XOR;
        return r;
    endfunction

    function automatic logic key_bit(input tl_regs_t r);
        return r.s1[0] ^ r.s2[0] ^ r.s3[0];
    endfunction

    function automatic tl_regs_t step_regs(input tl_regs_t r);
        tl_regs_t n;
        n.s1 = {r.s1[6:0], r.s2[0] ^ r.s3[1]};
        n.s2 = {r.s2[6:0], r.s3[3] ^ r.s1[1]};
        n.s3 = {r.s3[6:0], r.s1[5] ^ r.s2[2]};
        return n;
    endfunction

endpackage

// File: rtl/trivium_lite_ksgen.sv
// Keystream byte generator: holds the cipher registers and shifts one key bit per
// step; done marks the eighth step, after which ks holds a complete byte.
module trivium_lite_ksgen
    import trivium_lite_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic       done,
    output logic [7:0] ks
);

    tl_regs_t   regs_q, regs_d;
    logic [7:0] ks_q, ks_d;
    logic [2:0] step_q, step_d;

    // Load restarts the bit counter so an aborted byte never leaks into the next seed.
    always_comb begin
        regs_d = regs_q;
        ks_d   = ks_q;
        step_d = step_q;
        if (load) begin
            regs_d = seed_expand(seed);
            step_d = 3'd0;
        end else if (step) begin
            regs_d = step_regs(regs_q);
            ks_d   = {ks_q[6:0], key_bit(regs_q)};
            step_d = step_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= {INIT_S1, INIT_S2, INIT_S3};
            ks_q   <= 8'h00;
            step_q <= 3'd0;
        end else begin
            regs_q <= regs_d;
            ks_q   <= ks_d;
            step_q <= step_d;
        end
    end

    assign done = step && !load && (step_q == 3'd7);
    assign ks   = ks_q;

endmodule

// File: rtl/trivium_lite_rx.sv
// Receive-side trivium_lite decryptor: regenerates the keystream from the shared seed,
// optionally verifies a sync header, and hands plaintext bytes out over valid/ready.
module trivium_lite_rx
    import trivium_lite_pkg::*;
#(
    parameter bit         CHECK_SYNC = 1'b1,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [7:0]       seed,
    input  logic             abort,
    input  logic             ct_valid,
    input  logic [7:0]       ct_data,
    output logic             ct_ready,
    output logic             pt_valid,
    output logic [7:0]       pt_data,
    input  logic             pt_ready,
    output logic             locked,
    output logic             sync_err,
    output logic [CNT_W-1:0] byte_cnt
);

    tl_state_e        state_q, state_d;
    logic [7:0]       pt_data_q, pt_data_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;
    logic             hdr_pending_q, hdr_pending_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             ks_load, ks_step, ks_done;
    logic [7:0]       ks_byte;
    logic [7:0]       ct_plain;

    trivium_lite_ksgen u_ksgen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ks_load),
        .seed  (seed),
        .step  (ks_step),
        .done  (ks_done),
        .ks    (ks_byte)
    );

    assign ct_plain = ct_data ^ ks_byte;

    always_comb begin
        state_d       = state_q;
        pt_data_d     = pt_data_q;
        locked_d      = locked_q;
        sync_err_d    = sync_err_q;
        hdr_pending_d = hdr_pending_q;
        byte_cnt_d    = byte_cnt_q;
        ks_load       = 1'b0;
        ks_step       = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seed_valid && !seed_is_reserved(seed)) begin
                        ks_load       = 1'b1;
                        sync_err_d    = 1'b0;
                        byte_cnt_d    = '0;
                        locked_d      = !CHECK_SYNC;
                        hdr_pending_d = CHECK_SYNC;
                        state_d       = GEN;
                    end
                end
                GEN: begin
                    ks_step = 1'b1;
                    if (ks_done) state_d = WAIT_CT;
                end
                WAIT_CT: begin
                    if (ct_valid) begin
                        if (hdr_pending_q) begin
                            // Header is swallowed either way; a mismatch means the seeds disagree.
                            if (ct_plain == SYNC_BYTE) begin
                                locked_d      = 1'b1;
                                hdr_pending_d = 1'b0;
                                state_d       = GEN;
                            end else begin
                                sync_err_d = 1'b1;
                                locked_d   = 1'b0;
                                state_d    = IDLE;
                            end
                        end else begin
                            pt_data_d = ct_plain;
                            state_d   = EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (pt_ready) begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        state_d    = GEN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pt_data_q     <= 8'h00;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            hdr_pending_q <= 1'b0;
            byte_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pt_data_q     <= pt_data_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
            hdr_pending_q <= hdr_pending_d;
            byte_cnt_q    <= byte_cnt_d;
        end
    end

    assign ct_ready = (state_q == WAIT_CT);
    assign pt_valid = (state_q == EMIT);
    assign pt_data  = pt_data_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_trivium_lite_rx.sv
// Bench for trivium_lite_rx: one instance with the sync header, one without, checked
// against a bit-serial keystream model and a transmitter-side encryption model.
module tb_trivium_lite_rx;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        seed_valid, abort, ct_valid, pt_ready;
    logic [7:0]  seed, ct_data;
    logic        ct_ready, pt_valid, locked, sync_err;
    logic [7:0]  pt_data;
    logic [15:0] byte_cnt;

    logic        n_seed_valid, n_abort, n_ct_valid, n_pt_ready;
    logic [7:0]  n_seed, n_ct_data;
    logic        n_ct_ready, n_pt_valid, n_locked, n_sync_err;
    logic [7:0]  n_pt_data;
    logic [15:0] n_byte_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m1, m2, m3;

    always #5 clk = ~clk;

    trivium_lite_rx #(.CHECK_SYNC(1'b1), .SYNC_BYTE(8'hA5), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed), .abort(abort),
        .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready), .pt_valid(pt_valid),
        .pt_data(pt_data), .pt_ready(pt_ready), .locked(locked), .sync_err(sync_err),
        .byte_cnt(byte_cnt)
    );

    trivium_lite_rx #(.CHECK_SYNC(1'b0), .SYNC_BYTE(8'hA5), .CNT_W(16)) u_dut_nosync (
        .clk(clk), .rst_n(rst_n), .seed_valid(n_seed_valid), .seed(n_seed), .abort(n_abort),
        .ct_valid(n_ct_valid), .ct_data(n_ct_data), .ct_ready(n_ct_ready), .pt_valid(n_pt_valid),
        .pt_data(n_pt_data), .pt_ready(n_pt_ready), .locked(n_locked), .sync_err(n_sync_err),
        .byte_cnt(n_byte_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_seed(input logic [7:0] sd);
        m1 = sd;
        m2 = {~sd[3:0], sd[7:4]};
        m3 = sd ^ 8'hA5;
    endtask

    // Bit-serial keystream: the first bit produced lands in the byte's MSB.
    task automatic m_next(output logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            logic kb, b1, b2, b3;
            kb = m1[0] ^ m2[0] ^ m3[0];
            b1 = m2[0] ^ m3[1];
            b2 = m3[3] ^ m1[1];
            b3 = m1[5] ^ m2[2];
            k[7-i] = kb;
            m1 = {m1[6:0], b1};
            m2 = {m2[6:0], b2};
            m3 = {m3[6:0], b3};
        end
    endtask

    task automatic seed_and_wait(input logic [7:0] sd, output int cycles);
        seed_valid = 1'b1;
        seed = sd;
        tick();
        seed_valid = 1'b0;
        cycles = 1;
        while (!ct_ready && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ct_ready && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic send_byte(input logic [7:0] c, input int hold, output logic [7:0] got, output bit ok);
        int n = 0;
        ct_valid = 1'b1;
        ct_data = c;
        while (!pt_valid && n < 40) begin
            tick();
            n++;
        end
        ct_valid = 1'b0;
        ok = pt_valid;
        got = pt_data;
        repeat (hold) tick();
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (ct_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ct_ready: got %b expected 0", ct_ready); end
        n_cmp++; if (pt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pt_valid: got %b expected 0", pt_valid); end
        n_cmp++; if (pt_data !== 8'h00) begin n_bad++; $display("FAIL reset_pt_data: got %h expected 00", pt_data); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
        n_cmp++; if (byte_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt); end
        n_cmp++; if (n_locked !== 1'b0) begin n_bad++; $display("FAIL reset_nosync_locked: got %b expected 0", n_locked); end
    endtask

    task automatic test_vector_nosync();
        int cycles;
        logic [7:0] k, c;
        n_seed_valid = 1'b1;
        n_seed = 8'h01;
        tick();
        n_seed_valid = 1'b0;
        cycles = 1;
        while (!n_ct_ready && cycles < 40) begin tick(); cycles++; end
        n_cmp++; if (cycles !== 9) begin n_bad++; $display("FAIL nosync_seed_latency: got %0d expected 9", cycles); end
        n_cmp++; if (n_locked !== 1'b1) begin n_bad++; $display("FAIL nosync_locked: got %b expected 1", n_locked); end
        n_ct_valid = 1'b1;
        n_ct_data = 8'hD7;
        tick();
        n_ct_valid = 1'b0;
        n_cmp++; if (n_pt_valid !== 1'b1) begin n_bad++; $display("FAIL nosync_pt_valid: got %b expected 1", n_pt_valid); end
        n_cmp++; if (n_pt_data !== 8'h55) begin n_bad++; $display("FAIL nosync_vector_pt: got %h expected 55", n_pt_data); end
        n_pt_ready = 1'b1;
        tick();
        n_pt_ready = 1'b0;
        n_cmp++; if (n_byte_cnt !== 16'd1) begin n_bad++; $display("FAIL nosync_byte_cnt: got %0d expected 1", n_byte_cnt); end
        // Second byte decodes from the post-vector register state 01/00/04.
        m1 = 8'h01; m2 = 8'h00; m3 = 8'h04;
        m_next(k);
        c = 8'($urandom);
        cycles = 0;
        while (!n_ct_ready && cycles < 40) begin tick(); cycles++; end
        n_ct_valid = 1'b1;
        n_ct_data = c;
        tick();
        n_ct_valid = 1'b0;
        n_cmp++; if (n_pt_data !== (c ^ k)) begin n_bad++; $display("FAIL nosync_second_byte: got %h expected %h", n_pt_data, c ^ k); end
        n_pt_ready = 1'b1;
        tick();
        n_pt_ready = 1'b0;
    endtask

    task automatic test_reserved_seeds();
        int cycles;
        seed_and_wait(8'h00, cycles);
        n_cmp++; if (ct_ready !== 1'b0) begin n_bad++; $display("FAIL reserved_00_ct_ready: got %b expected 0", ct_ready); end
        seed_and_wait(8'hFF, cycles);
        n_cmp++; if (ct_ready !== 1'b0) begin n_bad++; $display("FAIL reserved_ff_ct_ready: got %b expected 0", ct_ready); end
    endtask

    task automatic test_sync_ok();
        int cycles;
        bit ok;
        logic [7:0] k, c, got;
        m_seed(8'h01);
        m_next(k);
        seed_and_wait(8'h01, cycles);
        n_cmp++; if (cycles !== 9) begin n_bad++; $display("FAIL seed_latency: got %0d expected 9", cycles); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL prelock: got %b expected 0", locked); end
        ct_valid = 1'b1;
        ct_data = 8'h27;
        tick();
        ct_valid = 1'b0;
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL hdr_locked: got %b expected 1", locked); end
        n_cmp++; if (pt_valid !== 1'b0) begin n_bad++; $display("FAIL hdr_no_pt_valid: got %b expected 0", pt_valid); end
        wait_ready(cycles);
        n_cmp++; if (cycles !== 8) begin n_bad++; $display("FAIL hdr_to_ready: got %0d expected 8", cycles); end
        for (int i = 0; i < 4; i++) begin
            m_next(k);
            c = 8'($urandom);
            send_byte(c, int'($urandom_range(0, 2)), got, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sync_byte_timeout: got %b expected 1", ok); end
            n_cmp++; if (got !== (c ^ k)) begin n_bad++; $display("FAIL sync_byte_pt: got %h expected %h", got, c ^ k); end
            n_cmp++; if (byte_cnt !== 16'(i + 1)) begin n_bad++; $display("FAIL sync_byte_cnt: got %0d expected %0d", byte_cnt, i + 1); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [7:0] k, c;
        m_next(k);
        c = 8'($urandom);
        ct_valid = 1'b1;
        ct_data = c;
        while (!pt_valid && n < 40) begin tick(); n++; end
        ct_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (pt_data !== (c ^ k)) begin n_bad++; $display("FAIL bp_pt_data: got %h expected %h", pt_data, c ^ k); end
            n_cmp++; if ({pt_valid, ct_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_handshake: got %b expected 10", {pt_valid, ct_ready}); end
            n_cmp++; if (byte_cnt !== 16'd4) begin n_bad++; $display("FAIL bp_byte_cnt: got %0d expected 4", byte_cnt); end
            tick();
        end
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        n_cmp++; if (byte_cnt !== 16'd5) begin n_bad++; $display("FAIL bp_release_cnt: got %0d expected 5", byte_cnt); end
        n_cmp++; if (pt_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b expected 0", pt_valid); end
    endtask

    task automatic test_abort_mid_gen();
        int cycles;
        bit seen = 1'b0;
        repeat (4) tick();
        do_abort();
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL abort_locked: got %b expected 0", locked); end
        n_cmp++; if (byte_cnt !== 16'd5) begin n_bad++; $display("FAIL abort_byte_cnt: got %0d expected 5", byte_cnt); end
        repeat (12) begin
            seen |= ct_ready;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b expected 0", seen); end
        seed_and_wait(8'h01, cycles);
        n_cmp++; if (cycles !== 9) begin n_bad++; $display("FAIL abort_reseed_latency: got %0d expected 9", cycles); end
        ct_valid = 1'b1;
        ct_data = 8'h27;
        tick();
        ct_valid = 1'b0;
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL abort_reseed_lock: got %b expected 1", locked); end
    endtask

    task automatic test_sync_bad();
        int cycles;
        do_abort();
        seed_and_wait(8'h01, cycles);
        ct_valid = 1'b1;
        ct_data = 8'h28;
        tick();
        ct_valid = 1'b0;
        n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL bad_hdr_sync_err: got %b expected 1", sync_err); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL bad_hdr_locked: got %b expected 0", locked); end
        tick();
        n_cmp++; if (ct_ready !== 1'b0) begin n_bad++; $display("FAIL bad_hdr_idle: got %b expected 0", ct_ready); end
        do_abort();
        n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL abort_keeps_err: got %b expected 1", sync_err); end
        seed_and_wait(8'h01, cycles);
        n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL reseed_clears_err: got %b expected 0", sync_err); end
        n_cmp++; if (cycles !== 9) begin n_bad++; $display("FAIL bad_reseed_latency: got %0d expected 9", cycles); end
    endtask

    task automatic test_reset_mid_emit();
        int n = 0;
        ct_valid = 1'b1;
        ct_data = 8'h27;
        tick();
        ct_data = 8'($urandom);
        while (!pt_valid && n < 40) begin tick(); n++; end
        ct_valid = 1'b0;
        n_cmp++; if (pt_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_emit: got %b expected 1", pt_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({ct_ready, pt_valid, locked, sync_err} !== 4'b0000) begin
            n_bad++; $display("FAIL async_reset_flags: got %b expected 0000", {ct_ready, pt_valid, locked, sync_err});
        end
        n_cmp++; if (pt_data !== 8'h00) begin n_bad++; $display("FAIL async_reset_pt_data: got %h expected 00", pt_data); end
        n_cmp++; if (byte_cnt !== 16'd0) begin n_bad++; $display("FAIL async_reset_byte_cnt: got %0d expected 0", byte_cnt); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        int cycles;
        bit ok;
        int bad = 0;
        logic [7:0] k, p, got;
        m_seed(8'h3C);
        m_next(k);
        seed_and_wait(8'h3C, cycles);
        n_cmp++; if (cycles !== 9) begin n_bad++; $display("FAIL loop_seed_latency: got %0d expected 9", cycles); end
        ct_valid = 1'b1;
        ct_data = 8'hA5 ^ k;
        tick();
        ct_valid = 1'b0;
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loop_locked: got %b expected 1", locked); end
        for (int i = 0; i < 256; i++) begin
            p = 8'($urandom);
            m_next(k);
            send_byte(p ^ k, int'($urandom_range(0, 2)), got, ok);
            n_cmp++;
            if (!ok || got !== p) begin
                n_bad++;
                if (bad < 8) $display("FAIL loop_byte_%0d: got %h expected %h", i, got, p);
                bad++;
            end
        end
        n_cmp++; if (byte_cnt !== 16'd256) begin n_bad++; $display("FAIL loop_byte_cnt: got %0d expected 256", byte_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        seed_valid = 1'b0; seed = 8'h00; abort = 1'b0;
        ct_valid = 1'b0; ct_data = 8'h00; pt_ready = 1'b0;
        n_seed_valid = 1'b0; n_seed = 8'h00; n_abort = 1'b0;
        n_ct_valid = 1'b0; n_ct_data = 8'h00; n_pt_ready = 1'b0;
        repeat (2) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_vector_nosync();
        test_reserved_seeds();
        test_sync_ok();
        test_backpressure();
        test_abort_mid_gen();
        test_sync_bad();
        test_reset_mid_emit();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
